// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared external ALU.
// Each accepted operation runs IDLE -> EXEC -> RESP and returns one tagged result.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_cmd,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_cmd,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic [3:0]  alu_cmd,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_oe,
    input  logic [15:0] alu_y,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [15:0] resp_data,
    output logic        resp_err,
    output logic        busy,
    output logic [15:0] op_count
);

    // state | meaning
    // IDLE  | waiting for a request; grant and latch operands
    // EXEC  | latched operation driven to the ALU, result captured
    // RESP  | result held until the consumer accepts it
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CMD_DIV = 4'b0101;

    state_t      r_state, w_next;
    logic        r_last, r_id, r_err;
    logic [3:0]  r_cmd;
    logic [7:0]  r_a, r_b;
    logic [15:0] r_data, r_op_count;
    logic        w_gnt0, w_gnt1, w_accept, w_done, w_div0;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            // r_last == 1 means requester 1 was served last, so 0 wins the tie
            if (RR_EN && (r_last == 1'b0))
                w_gnt1 = 1'b1;
            else
                w_gnt0 = 1'b1;
        end else begin
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid;
        end
    end

    assign w_accept = (r_state == IDLE) && (req0_valid || req1_valid);
    assign w_done   = (r_state == RESP) && resp_ready;
    assign w_div0   = (r_cmd == CMD_DIV) && (r_b == 8'd0);

    always_comb begin
        w_next     = r_state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_oe     = 1'b0;
        case (r_state)
            IDLE: begin
                // gated by rst_n so a held request never sees ready during reset
                req0_ready = rst_n & w_gnt0;
                req1_ready = rst_n & w_gnt1;
                if (w_accept)
                    w_next = EXEC;
            end
            EXEC: begin
                alu_oe = 1'b1;
                w_next = RESP;
            end
            RESP: begin
                if (resp_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= 1'b1;
            r_id       <= 1'b0;
            r_cmd      <= 4'd0;
            r_a        <= 8'd0;
            r_b        <= 8'd0;
            r_data     <= 16'd0;
            r_err      <= 1'b0;
            r_op_count <= 16'd0;
        end else begin
            if (w_accept) begin
                r_id  <= w_gnt1;
                r_cmd <= w_gnt1 ? req1_cmd : req0_cmd;
                r_a   <= w_gnt1 ? req1_a   : req0_a;
                r_b   <= w_gnt1 ? req1_b   : req0_b;
            end
            if (r_state == EXEC) begin
                r_data <= w_div0 ? 16'hFFFF : alu_y;
                r_err  <= w_div0;
            end
            if (w_done) begin
                r_last <= r_id;
                if (r_op_count != 16'hFFFF)
                    r_op_count <= r_op_count + 16'd1;
            end
        end
    end

    assign alu_cmd    = r_cmd;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign resp_valid = (r_state == RESP);
    assign resp_id    = r_id;
    assign resp_data  = r_data;
    assign resp_err   = r_err;
    assign busy       = (r_state != IDLE);
    assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance plus a fixed-priority
// instance sharing the same stimulus, each driving its own behavioural ALU.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, resp_ready;
    logic [3:0]  req0_cmd, req1_cmd;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;

    logic        req0_ready, req1_ready, alu_oe, resp_valid, resp_id, resp_err, busy;
    logic [3:0]  alu_cmd;
    logic [7:0]  alu_a, alu_b;
    logic [15:0] alu_y, resp_data, op_count;

    logic        fp_req0_ready, fp_req1_ready, fp_alu_oe, fp_resp_valid, fp_resp_id, fp_resp_err, fp_busy;
    logic [3:0]  fp_alu_cmd;
    logic [7:0]  fp_alu_a, fp_alu_b;
    logic [15:0] fp_alu_y, fp_resp_data, fp_op_count;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, MUL = 4'h2, DIV = 4'h5;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_model(input logic oe, input logic [3:0] c,
                                              input logic [7:0] a, input logic [7:0] b);
        logic [15:0] y;
        if (!oe)
            y = 16'h0BAD;
        else begin
            case (c)
                ADD:     y = {8'h0, a} + {8'h0, b};
                SUB:     y = {8'h0, a} - {8'h0, b};
                MUL:     y = {8'h0, a} * {8'h0, b};
                DIV:     y = (b == 8'd0) ? 16'h1234 : {8'h0, a / b};
                default: y = {a, b};
            endcase
        end
        return y;
    endfunction

    assign alu_y    = alu_model(alu_oe, alu_cmd, alu_a, alu_b);
    assign fp_alu_y = alu_model(fp_alu_oe, fp_alu_cmd, fp_alu_a, fp_alu_b);

    alu_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd), .req1_a(req1_a), .req1_b(req1_b),
        .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b), .alu_oe(alu_oe), .alu_y(alu_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
        .resp_err(resp_err), .busy(busy), .op_count(op_count)
    );

    alu_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_cmd(req0_cmd), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_cmd(req1_cmd), .req1_a(req1_a), .req1_b(req1_b),
        .alu_cmd(fp_alu_cmd), .alu_a(fp_alu_a), .alu_b(fp_alu_b), .alu_oe(fp_alu_oe), .alu_y(fp_alu_y),
        .resp_valid(fp_resp_valid), .resp_ready(resp_ready), .resp_id(fp_resp_id), .resp_data(fp_resp_data),
        .resp_err(fp_resp_err), .busy(fp_busy), .op_count(fp_op_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle just after the edge; returns in the next IDLE cycle.
    task automatic do_op(input logic id, input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_d, input logic exp_e);
        if (id) begin
            req1_valid = 1'b1; req1_cmd = cmd; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_cmd = cmd; req0_a = a; req0_b = b;
        end
        #1;
        chk("op_req0_ready", {15'd0, req0_ready}, {15'd0, ~id});
        chk("op_req1_ready", {15'd0, req1_ready}, {15'd0, id});
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("op_exec_oe", {15'd0, alu_oe}, 16'd1);
        chk("op_exec_cmd", {12'd0, alu_cmd}, {12'd0, cmd});
        chk("op_exec_valid", {15'd0, resp_valid}, 16'd0);
        step();
        chk("op_resp_valid", {15'd0, resp_valid}, 16'd1);
        chk("op_resp_data", resp_data, exp_d);
        chk("op_resp_err", {15'd0, resp_err}, {15'd0, exp_e});
        chk("op_resp_id", {15'd0, resp_id}, {15'd0, id});
        chk("op_resp_oe", {15'd0, alu_oe}, 16'd0);
        step();
        chk("op_idle_busy", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_cmd = ADD; req0_a = 8'd0; req0_b = 8'd0;
        req1_valid = 1'b0; req1_cmd = ADD; req1_a = 8'd0; req1_b = 8'd0;
        resp_ready = 1'b1;
        #3;
        chk("rst_req0_ready", {15'd0, req0_ready}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_resp_valid", {15'd0, resp_valid}, 16'd0);
        chk("rst_alu_oe", {15'd0, alu_oe}, 16'd0);
        chk("rst_resp_data", resp_data, 16'd0);
        chk("rst_resp_id", {15'd0, resp_id}, 16'd0);
        chk("rst_op_count", op_count, 16'd0);
        step();
        step();
        rst_n = 1'b1;
        req0_valid = 1'b0;
        step();

        // single ADD 200+100
        do_op(1'b0, ADD, 8'd200, 8'd100, 16'd300, 1'b0);
        chk("single_op_count", op_count, 16'd1);

        // reset during EXEC abandons the operation
        req1_valid = 1'b1; req1_cmd = ADD; req1_a = 8'd1; req1_b = 8'd1;
        step();
        req1_valid = 1'b0;
        chk("midrst_in_exec", {15'd0, alu_oe}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {15'd0, busy}, 16'd0);
        chk("midrst_alu_oe", {15'd0, alu_oe}, 16'd0);
        chk("midrst_op_count", op_count, 16'd0);
        chk("midrst_resp_data", resp_data, 16'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_no_resp", {15'd0, resp_valid}, 16'd0);
        end
        chk("midrst_count_after", op_count, 16'd0);

        // simultaneous requests: RR alternates 0,1,0,1; fixed priority serves 0 only
        req0_valid = 1'b1; req0_cmd = MUL; req0_a = 8'd15; req0_b = 8'd15;
        req1_valid = 1'b1; req1_cmd = SUB; req1_a = 8'd5;  req1_b = 8'd3;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("tie_rr_req0_ready", {15'd0, req0_ready}, (k % 2 == 0) ? 16'd1 : 16'd0);
            chk("tie_rr_req1_ready", {15'd0, req1_ready}, (k % 2 == 1) ? 16'd1 : 16'd0);
            chk("tie_fp_req0_ready", {15'd0, fp_req0_ready}, 16'd1);
            step();
            step();
            chk("tie_rr_resp_id", {15'd0, resp_id}, (k % 2 == 1) ? 16'd1 : 16'd0);
            chk("tie_rr_resp_data", resp_data, (k % 2 == 1) ? 16'd2 : 16'd225);
            chk("tie_fp_resp_id", {15'd0, fp_resp_id}, 16'd0);
            chk("tie_fp_resp_data", fp_resp_data, 16'd225);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk("tie_rr_op_count", op_count, 16'd4);
        chk("tie_fp_op_count", fp_op_count, 16'd4);
        step();

        // divide by zero, then a normal divide
        do_op(1'b1, DIV, 8'd9, 8'd0, 16'hFFFF, 1'b1);
        do_op(1'b1, DIV, 8'd9, 8'd3, 16'd3, 1'b0);
        chk("div_op_count", op_count, 16'd6);

        // backpressure with a competing request arriving during the operation
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_cmd = ADD; req0_a = 8'd7; req0_b = 8'd8;
        #1;
        chk("bp_accept", {15'd0, req0_ready}, 16'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_cmd = ADD; req1_a = 8'd2; req1_b = 8'd3;
        chk("bp_exec_req1_ready", {15'd0, req1_ready}, 16'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp_valid", {15'd0, resp_valid}, 16'd1);
            chk("bp_resp_data", resp_data, 16'd15);
            chk("bp_busy", {15'd0, busy}, 16'd1);
            chk("bp_req1_ready", {15'd0, req1_ready}, 16'd0);
            chk("bp_alu_oe", {15'd0, alu_oe}, 16'd0);
            step();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_valid", {15'd0, resp_valid}, 16'd1);
        step();
        chk("bp_idle_count", op_count, 16'd7);
        chk("bp_held_req1_ready", {15'd0, req1_ready}, 16'd1);
        step();
        req1_valid = 1'b0;
        step();
        chk("bp_req1_data", resp_data, 16'd5);
        chk("bp_req1_id", {15'd0, resp_id}, 16'd1);
        step();
        chk("bp_final_count", op_count, 16'd8);

        // saturation near the top of the counter range
        force dut.r_op_count = 16'hFFFE;
        #1;
        release dut.r_op_count;
        do_op(1'b0, ADD, 8'd1, 8'd1, 16'd2, 1'b0);
        chk("sat_reach_max", op_count, 16'hFFFF);
        do_op(1'b0, ADD, 8'd1, 8'd2, 16'd3, 1'b0);
        chk("sat_hold_max", op_count, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
